// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and its parity helper.
//   tx_state_e   - transmitter FSM states, 3-bit encoding
//   IDLE_LEVEL   - level driven on the line when no frame is in flight
//   START_BIT    - level of the start bit
//   STOP_BIT     - level of the stop bit
//   PAR_ODD/EVEN - encodings of the parity-type select input
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic IDLE_LEVEL = 1'b1;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

    localparam logic PAR_ODD    = 1'b1;
    localparam logic PAR_EVEN   = 1'b0;

endpackage : uart_pkg

// File: rtl/uart_tx_parity_calc.sv
// uart_tx_parity_calc: purely combinational parity generator.
//   data_i    in  DATA_WIDTH  word to protect
//   par_typ_i in  1           PAR_ODD or PAR_EVEN
//   parity_o  out 1           parity bit to place on the line
// Even parity is the XOR of all data bits; odd parity is its complement,
// so that the data bits plus the parity bit hold an odd number of ones.
module uart_tx_parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  par_typ_i,
    output logic                  parity_o
);

    logic even_par;

    assign even_par = ^data_i;
    assign parity_o = (par_typ_i == PAR_ODD) ? ~even_par : even_par;

endmodule : uart_tx_parity_calc

// File: rtl/uart_tx.sv
// uart_tx: single-clock UART transmitter, one line bit per clock cycle.
// Frame: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit.
//   clk        in  1  system clock, rising edge
//   rst_n      in  1  synchronous active-low reset
//   P_DATA     in  8  parallel word, latched when a request is accepted
//   Data_Valid in  1  request strobe
//   Par_En     in  1  1 = append a parity bit after the data bits
//   Par_Typ    in  1  1 = odd parity, 0 = even parity
//   TX_OUT     out 1  serial line (registered, idles high)
//   Busy       out 1  high from the start bit through the stop bit (registered)
// Requests are accepted only in IDLE or STOP, so a STOP cycle can flow
// straight into the next START with no idle gap on the line.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  Par_En,
    input  logic                  Par_Typ,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_WIDTH - 1);

    tx_state_e             state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;

    logic                  accept;
    logic                  parity_bit;

    uart_tx_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data_i    (data_q),
        .par_typ_i (Par_Typ),
        .parity_o  (parity_bit)
    );

    assign accept = Data_Valid && ((state_q == IDLE) || (state_q == STOP));

    // The line level and Busy are computed for the state being entered and
    // registered together with it, so the outputs always match state_q.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        tx_d      = tx_q;
        busy_d    = busy_q;

        case (state_q)
            IDLE, STOP: begin
                if (accept) begin
                    state_d = START;
                    data_d  = P_DATA;
                    tx_d    = START_BIT;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                    tx_d    = IDLE_LEVEL;
                    busy_d  = 1'b0;
                end
            end

            START: begin
                state_d   = DATA;
                bit_cnt_d = 3'd0;
                tx_d      = data_q[0];
                busy_d    = 1'b1;
            end

            DATA: begin
                busy_d = 1'b1;
                if (bit_cnt_q == LAST_BIT) begin
                    // Parity enable and type are looked at only on this edge.
                    bit_cnt_d = 3'd0;
                    if (Par_En) begin
                        state_d = PARITY;
                        tx_d    = parity_bit;
                    end else begin
                        state_d = STOP;
                        tx_d    = STOP_BIT;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    tx_d      = data_q[bit_cnt_q + 3'd1];
                end
            end

            PARITY: begin
                state_d = STOP;
                tx_d    = STOP_BIT;
                busy_d  = 1'b1;
            end

            default: begin
                state_d   = IDLE;
                bit_cnt_d = 3'd0;
                tx_d      = IDLE_LEVEL;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
            data_q    <= '0;
            tx_q      <= IDLE_LEVEL;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

    logic       clk;
    logic       rst_n;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       Par_En;
    logic       Par_Typ;
    logic       TX_OUT;
    logic       Busy;

    typedef struct packed {
        logic busy;
        logic tx;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;

    uart_tx #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .Par_En     (Par_En),
        .Par_Typ    (Par_Typ),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: samples 2 time units after each rising edge. While the
    // scoreboard holds expectations, each cycle consumes one; otherwise the
    // line must be idle (Busy=0, TX_OUT=1).
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (mon_en) begin
                checks++;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    if ({Busy, TX_OUT} !== {e.busy, e.tx}) begin
                        errors++;
                        $display("FAIL frame_bit t=%0t got busy=%b tx=%b want busy=%b tx=%b",
                                 $time, Busy, TX_OUT, e.busy, e.tx);
                    end
                end else if ({Busy, TX_OUT} !== 2'b01) begin
                    errors++;
                    $display("FAIL idle_line t=%0t got busy=%b tx=%b want busy=0 tx=1",
                             $time, Busy, TX_OUT);
                end
            end
        end
    end

    // Queue the expected line levels of one frame; only the first 'keep'
    // cycles are queued (used for the aborted frame). pbit is hand-computed.
    task automatic push_frame(input logic [7:0] d, input logic pe,
                              input logic pbit, input int keep);
        exp_t q[$];
        q.push_back('{busy: 1'b1, tx: 1'b0});
        for (int i = 0; i < 8; i++) q.push_back('{busy: 1'b1, tx: d[i]});
        if (pe) q.push_back('{busy: 1'b1, tx: pbit});
        q.push_back('{busy: 1'b1, tx: 1'b1});
        for (int i = 0; i < q.size() && i < keep; i++) sb.push_back(q[i]);
    endtask

    // Drive a one-cycle request at a falling edge and queue its frame.
    task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                        input logic pbit, input int keep);
        @(negedge clk);
        P_DATA     = d;
        Par_En     = pe;
        Par_Typ    = pt;
        Data_Valid = 1'b1;
        push_frame(d, pe, pbit, keep);
        $display("send data=%h par_en=%b par_typ=%b", d, pe, pt);
        @(negedge clk);
        Data_Valid = 1'b0;
    endtask

    task automatic drain(input string name, input int cycles);
        repeat (cycles) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got %0d pending want 0", name, sb.size());
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        P_DATA     = 8'h00;
        Data_Valid = 1'b0;
        Par_En     = 1'b0;
        Par_Typ    = 1'b0;

        // Reset held two edges, then checked while still low and for 10 idle cycles.
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // No parity: expect 0,1,0,1,0,0,1,0,1,1.
        send(8'hA5, 1'b0, 1'b0, 1'b0, 99);
        drain("nopar_a5", 13);

        // Parity frames.
        send(8'h07, 1'b1, 1'b0, 1'b1, 99);
        drain("even_07", 14);
        send(8'h07, 1'b1, 1'b1, 1'b0, 99);
        drain("odd_07", 14);
        send(8'h03, 1'b1, 1'b1, 1'b1, 99);
        drain("odd_03", 14);

        // Back-to-back: request held high, second word taken on the STOP edge.
        @(negedge clk);
        P_DATA     = 8'h55;
        Par_En     = 1'b0;
        Data_Valid = 1'b1;
        push_frame(8'h55, 1'b0, 1'b0, 99);
        push_frame(8'h0F, 1'b0, 1'b0, 99);
        $display("send back-to-back data=55 then 0f");
        @(negedge clk);
        P_DATA = 8'h0F;
        repeat (10) @(negedge clk);
        Data_Valid = 1'b0;
        drain("b2b", 14);

        // Request raised only during the DATA bits of a frame is ignored.
        send(8'h00, 1'b0, 1'b0, 1'b0, 99);
        @(negedge clk);
        P_DATA     = 8'hFF;
        Data_Valid = 1'b1;
        $display("ignored request data=ff during data bits");
        repeat (4) @(negedge clk);
        Data_Valid = 1'b0;
        drain("ignored", 16);

        // Reset while data bit 3 is on the line: START and bits 0..3 are
        // seen, then the line is idle.
        send(8'h3C, 1'b0, 1'b0, 1'b0, 5);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        $display("reset during data bit 3");
        @(negedge clk);
        rst_n = 1'b1;
        drain("abort", 4);

        // Clean frame after the abort.
        send(8'hC3, 1'b1, 1'b0, 1'b0, 99);
        drain("after_abort", 15);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_tx

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Single-clock UART transmitter. Accepts one 8-bit parallel word on a valid strobe and serialises it onto TX_OUT, one bit per clock: start, 8 data bits LSB first, optional parity, stop.
- Sits between the system-side register/FIFO interface and the serial pin.
- Busy tells the upstream side when a frame is in flight.
- Baud rate equals the clock rate; any prescaling is done by the clock source, not by this block.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (fixed at 8 for this release).

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  reset, synchronous and active-low.
- P_DATA  in  8  parallel data word; captured when accepted.
- Data_Valid  in  1  request strobe; P_DATA is valid while it is high.
- Par_En  in  1  1 = insert a parity bit after the data bits.
- Par_Typ  in  1  parity type: 1 = odd, 0 = even.
- TX_OUT  out  1  serial line output; idles high.
- Busy  out  1  frame in progress.

Behaviour:
- Reset: rst_n=0 at a rising edge forces the IDLE state, TX_OUT=1, Busy=0, and clears the bit counter and data register. This applies mid-frame too: the frame is aborted and the next cycle is idle.
- TX_OUT and Busy are registered; they change only on rising edges.
- States:
  - IDLE: TX_OUT=1, Busy=0.
  - START: TX_OUT=0, Busy=1.
  - DATA: 8 cycles, TX_OUT=data[i] for i=0..7, Busy=1.
  - PARITY: optional, TX_OUT=parity bit, Busy=1.
  - STOP: TX_OUT=1, Busy=1.
- Each state lasts exactly one clock cycle; DATA lasts 8 cycles.
- Acceptance: a request is accepted on a rising edge where Data_Valid=1 and the FSM is in IDLE or STOP.
  - P_DATA is latched into the internal register.
  - The next cycle is START, so latency is one cycle from the accepting edge to the start bit.
- Data_Valid is ignored in START, DATA and PARITY. A request held across a frame is not queued; it is accepted only when it is present at an IDLE/STOP edge.
- Transitions:
  - IDLE -> START on accept.
  - START -> DATA.
  - DATA -> DATA until bit 7 has been sent.
  - From the last DATA bit: -> PARITY if Par_En=1, else -> STOP.
  - PARITY -> STOP.
  - STOP -> START on accept (back-to-back frames with no idle gap), else -> IDLE.
- Configuration sampling: Par_En and Par_Typ are sampled on the edge that leaves the last data bit. That edge both chooses PARITY or STOP and computes the parity bit. Changes at other times do not affect the frame in flight.
- Parity is computed over the latched data:
  - even parity = XOR of the 8 bits;
  - odd parity = XNOR of the 8 bits.
- Frame length, Busy high cycles per frame: 10 without parity, 11 with parity. Busy rises in the START cycle and stays high through the STOP cycle.
- The bit counter is 3 bits and is used only in DATA. It wraps from 7 to 0 on leaving DATA.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP) with a 3-bit encoding;
  - the constants IDLE_LEVEL=1, START_BIT=0, STOP_BIT=1;
  - the parity-type encodings PAR_ODD=1 and PAR_EVEN=0.
- One natural sub-module, uart_tx_parity_calc: a combinational parity generator (data, Par_Typ) -> parity bit.
- The FSM, the serializer register and the output mux stay in uart_tx.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> TX_OUT=1, Busy=0. With no Data_Valid for 10 cycles the outputs stay 1/0.
- No parity: P_DATA=8'hA5, Data_Valid pulsed 1 cycle, Par_En=0 -> starting the cycle after acceptance, TX_OUT sequence = 0,1,0,1,0,0,1,0,1,1. Busy=1 for exactly 10 cycles, then 0.
- Even and odd parity:
  - P_DATA=8'h07, Par_En=1, Par_Typ=0 -> parity bit=1, frame of 11 bits ending ...1,1.
  - Same data with Par_Typ=1 -> parity bit=0.
  - P_DATA=8'h03 with Par_Typ=1 -> parity bit=1.
- Back-to-back: Data_Valid held high with 8'h55 then 8'h0F (Par_En=0) -> the second start bit is in the cycle immediately after the first stop bit. Busy never drops between frames.
- Ignored request: assert Data_Valid with 8'hFF during the DATA state of an 8'h00 frame, then deassert it before STOP -> the first frame is unaffected and the block returns to IDLE with no second frame.
- Mid-frame reset: rst_n=0 during data bit 3 -> next cycle TX_OUT=1, Busy=0. A new request afterwards produces a clean, complete frame.
